// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch sequencer.
package fetch_pkg;

  localparam int unsigned OP_W      = 8;
  localparam int unsigned OPLEN_LSB = 6;
  localparam logic [OP_W-1:0] HALT_OPCODE_DEF = 8'hFF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH_OP  = 3'd1,
    CAP_OP    = 3'd2,
    FETCH_ARG = 3'd3,
    CAP_ARG   = 3'd4,
    ISSUE     = 3'd5,
    HALT      = 3'd6
  } fetch_state_e;

  // Operand count encoded in the top two opcode bits; 2'b11 carries no operands.
  function automatic logic [1:0] oplen(input logic [OP_W-1:0] opcode);
    logic [1:0] field;
    field = opcode[OPLEN_LSB +: 2];
    return (field == 2'b11) ? 2'd0 : field;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Walks the PC through ROM, assembles opcode + operands and hands each
// instruction to the decoder; honours decoder jumps and stops on HALT.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned          BYTE        = 8,
  parameter int unsigned          ADDR_W      = 8,
  parameter logic [ADDR_W-1:0]    RESET_PC    = '0,
  parameter logic [BYTE-1:0]      HALT_OPCODE = BYTE'(HALT_OPCODE_DEF)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  output logic                rom_en,
  output logic [ADDR_W-1:0]   rom_address,
  input  logic [BYTE-1:0]     data_from_rom,
  output logic                start_for_decoder,
  input  logic                ready_from_decoder,
  output logic [BYTE-1:0]     instr_opcode,
  output logic [2*BYTE-1:0]   instr_operands,
  output logic [1:0]          instr_len,
  output logic [ADDR_W-1:0]   instr_pc,
  input  logic                jump_valid,
  input  logic [ADDR_W-1:0]   jump_target,
  output logic                halted
);

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                arg_idx_q, arg_idx_d;
  logic                rom_en_q, rom_en_d;
  logic                start_q, start_d;
  logic                halted_q, halted_d;
  logic [BYTE-1:0]     opcode_q, opcode_d;
  logic [2*BYTE-1:0]   operands_q, operands_d;
  logic [1:0]          len_q, len_d;
  logic [ADDR_W-1:0]   ipc_q, ipc_d;
  logic [1:0]          cap_len;
  logic                jump_take;

  assign cap_len   = oplen(OP_W'(data_from_rom));
  assign jump_take = jump_valid && (state_q != IDLE) && (state_q != HALT);

  // Next-state, PC and instruction-field logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    arg_idx_d  = arg_idx_q;
    opcode_d   = opcode_q;
    operands_d = operands_q;
    len_d      = len_q;
    ipc_d      = ipc_q;

    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH_OP;
      end
      FETCH_OP: begin
        ipc_d   = pc_q;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = CAP_OP;
      end
      CAP_OP: begin
        opcode_d   = data_from_rom;
        operands_d = '0;
        arg_idx_d  = 1'b0;
        if (data_from_rom == HALT_OPCODE) begin
          len_d   = 2'd0;
          state_d = HALT;
        end else if (cap_len == 2'd0) begin
          len_d   = 2'd0;
          state_d = ISSUE;
        end else begin
          len_d   = cap_len;
          state_d = FETCH_ARG;
        end
      end
      FETCH_ARG: begin
        pc_d    = pc_q + ADDR_W'(1);
        state_d = CAP_ARG;
      end
      CAP_ARG: begin
        if (arg_idx_q) operands_d[2*BYTE-1:BYTE] = data_from_rom;
        else           operands_d[BYTE-1:0]      = data_from_rom;
        if ((2'(arg_idx_q) + 2'd1) == len_q) begin
          state_d = ISSUE;
        end else begin
          arg_idx_d = 1'b1;
          state_d   = FETCH_ARG;
        end
      end
      ISSUE: begin
        if (ready_from_decoder) state_d = FETCH_OP;
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = IDLE;
    endcase

    // A redirect discards whatever was partially assembled this cycle.
    if (jump_take) begin
      state_d    = FETCH_OP;
      pc_d       = jump_target;
      arg_idx_d  = arg_idx_q;
      opcode_d   = opcode_q;
      operands_d = operands_q;
      len_d      = len_q;
      ipc_d      = ipc_q;
    end
  end

  // Outputs are registered images of the state being entered.
  always_comb begin
    rom_en_d = (state_d == FETCH_OP) || (state_d == FETCH_ARG);
    start_d  = (state_d == ISSUE);
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      arg_idx_q  <= 1'b0;
      rom_en_q   <= 1'b0;
      start_q    <= 1'b0;
      halted_q   <= 1'b0;
      opcode_q   <= '0;
      operands_q <= '0;
      len_q      <= 2'd0;
      ipc_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      arg_idx_q  <= arg_idx_d;
      rom_en_q   <= rom_en_d;
      start_q    <= start_d;
      halted_q   <= halted_d;
      opcode_q   <= opcode_d;
      operands_q <= operands_d;
      len_q      <= len_d;
      ipc_q      <= ipc_d;
    end
  end

  assign rom_en            = rom_en_q;
  assign rom_address       = pc_q;
  assign start_for_decoder = start_q;
  assign instr_opcode      = opcode_q;
  assign instr_operands    = operands_q;
  assign instr_len         = len_q;
  assign instr_pc          = ipc_q;
  assign halted            = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a synchronous ROM model and
// hand-computed expectations for issue timing, jumps, wrap and halt.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic        rom_en;
  logic [7:0]  rom_address;
  logic [7:0]  data_from_rom;
  logic        start_for_decoder;
  logic        ready_from_decoder;
  logic [7:0]  instr_opcode;
  logic [15:0] instr_operands;
  logic [1:0]  instr_len;
  logic [7:0]  instr_pc;
  logic        jump_valid;
  logic [7:0]  jump_target;
  logic        halted;

  logic [7:0]  rom [0:255];
  int          n_checks;
  int          n_pass;
  int          accepts;
  int          acc_before;

  fetch_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .run                (run),
    .rom_en             (rom_en),
    .rom_address        (rom_address),
    .data_from_rom      (data_from_rom),
    .start_for_decoder  (start_for_decoder),
    .ready_from_decoder (ready_from_decoder),
    .instr_opcode       (instr_opcode),
    .instr_operands     (instr_operands),
    .instr_len          (instr_len),
    .instr_pc           (instr_pc),
    .jump_valid         (jump_valid),
    .jump_target        (jump_target),
    .halted             (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_en) data_from_rom <= rom[rom_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock; decoder acceptances are counted from the pre-edge values.
  task automatic step();
    if (start_for_decoder && ready_from_decoder) accepts++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_start(input string tag, input int exp_cycles);
    int n;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (start_for_decoder) begin
        n = i;
        break;
      end
    end
    if (n == 0) n = 41;
    check(tag, 32'(n), 32'(exp_cycles));
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run   = 1'b0;
    jump_valid = 1'b0;
    jump_target = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    accepts  = 0;
    data_from_rom = 8'h00;
    ready_from_decoder = 1'b1;
    clear_rom();

    // Phase A: sequential program, stall, halt.
    rom[0] = 8'h05;
    rom[1] = 8'h83; rom[2] = 8'hAA; rom[3] = 8'h55;
    rom[4] = 8'h41; rom[5] = 8'h3C;
    rom[6] = 8'hFF;
    do_reset();
    check("rst_start", 32'(start_for_decoder), 0);
    check("rst_rom_en", 32'(rom_en), 0);
    check("rst_addr", 32'(rom_address), 0);
    check("rst_fields", {instr_opcode, instr_operands, 6'(instr_len), 2'b0}, 0);
    check("rst_halted", 32'(halted), 0);
    step();
    check("idle_no_run", 32'(rom_en), 0);

    run = 1'b1;
    step();
    run = 1'b0;
    check("fetch0_en", 32'(rom_en), 1);
    check("fetch0_addr", 32'(rom_address), 32'h00);
    wait_start("lat_op05", 2);
    check("op05_opcode", 32'(instr_opcode), 32'h05);
    check("op05_len", 32'(instr_len), 0);
    check("op05_operands", 32'(instr_operands), 0);
    check("op05_pc", 32'(instr_pc), 0);

    wait_start("thru_op83", 7);
    check("op83_opcode", 32'(instr_opcode), 32'h83);
    check("op83_len", 32'(instr_len), 2);
    check("op83_operands", 32'(instr_operands), 32'h55AA);
    check("op83_pc", 32'(instr_pc), 1);
    check("op83_pc_next", 32'(rom_address), 4);

    step();
    check("after83_start", 32'(start_for_decoder), 0);
    check("after83_addr", 32'(rom_address), 4);
    ready_from_decoder = 1'b0;
    wait_start("lat_op41", 4);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_start", 32'(start_for_decoder), 1);
      check("stall_fields", {instr_opcode, instr_operands, instr_pc}, 32'h41003C04);
    end
    ready_from_decoder = 1'b1;
    step();
    check("release_start", 32'(start_for_decoder), 0);
    check("release_addr", 32'(rom_address), 6);
    check("release_en", 32'(rom_en), 1);
    step();
    step();
    check("halt_flag", 32'(halted), 1);
    check("halt_rom_en", 32'(rom_en), 0);
    jump_valid = 1'b1;
    jump_target = 8'h20;
    step();
    jump_valid = 1'b0;
    step();
    check("halt_jump_ign", {24'(rom_address), 4'(halted), 4'(start_for_decoder)}, 32'h00000710);
    check("halt_accepts", 32'(accepts), 3);

    // Phase B: jump mid-operand, jump coincident with transfer, reset mid-ISSUE.
    clear_rom();
    rom[0] = 8'h80; rom[1] = 8'h11; rom[2] = 8'h22;
    rom[8'h20] = 8'h05;
    do_reset();
    run = 1'b1;
    step();
    run = 1'b0;
    step();
    step();
    step();
    jump_valid = 1'b1;
    jump_target = 8'h20;
    step();
    jump_valid = 1'b0;
    check("jump_addr", 32'(rom_address), 32'h20);
    check("jump_en", 32'(rom_en), 1);
    check("jump_start", 32'(start_for_decoder), 0);
    wait_start("jump_lat", 2);
    check("jump_op", {instr_opcode, instr_operands, instr_pc}, 32'h05000020);
    acc_before = accepts;
    jump_valid = 1'b1;
    step();
    jump_valid = 1'b0;
    check("cojump_accept", 32'(accepts), 32'(acc_before + 1));
    check("cojump_start", 32'(start_for_decoder), 0);
    check("cojump_addr", 32'(rom_address), 32'h20);
    ready_from_decoder = 1'b0;
    wait_start("cojump_lat", 2);
    step();
    check("pre_rst_start", 32'(start_for_decoder), 1);
    reset = 1'b0;
    #1;
    check("async_start", 32'(start_for_decoder), 0);
    check("async_addr", 32'(rom_address), 0);
    check("async_fields", {instr_opcode, instr_operands, instr_pc}, 0);
    @(negedge clk);
    reset = 1'b1;
    ready_from_decoder = 1'b1;
    step();
    check("post_rst_idle", {31'(rom_en), start_for_decoder}, 0);

    // Phase C: operand fetch wraps from FF to 00.
    clear_rom();
    rom[8'hFF] = 8'h41;
    rom[8'h00] = 8'h77;
    do_reset();
    run = 1'b1;
    step();
    run = 1'b0;
    jump_valid = 1'b1;
    jump_target = 8'hFF;
    step();
    jump_valid = 1'b0;
    check("wrap_addr", 32'(rom_address), 32'hFF);
    wait_start("wrap_lat", 4);
    check("wrap_operands", 32'(instr_operands), 32'h0077);
    check("wrap_pc", 32'(instr_pc), 32'hFF);
    check("wrap_len", 32'(instr_len), 1);
    check("wrap_next", 32'(rom_address), 32'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
